// File: rtl/oflow_mem_buffer_line_feeder.sv
// oflow_mem_buffer_line_feeder
// Takes history-frame lines from the MEM buffer read path, holds them in a
// small line FIFO and hands them one bbox at a time to the similarity-metric
// stage. Line requests to the MEM buffer read FSM are credit-limited, so
// the FIFO cannot overflow while the read FSM follows the protocol.
//
// Optional build macro: OFLOW_LINE_FEEDER_STATS_EN adds bbox_count[15:0],
// a count of bbox handshakes in the current run.
//
// Ports:
//   clk, reset_N        clock, synchronous active-low reset
//   start_feed          one-cycle pulse that starts a run (honoured in IDLE only)
//   num_of_history_frames  frames to consume, sampled with start_feed
//   similarity_metric_flag_ready_to_read_new_line  one-cycle line request
//   line_valid/line_data/line_mask/line_last_of_frame  incoming line
//   bbox_valid/bbox_ready/bbox_data/bbox_history_idx/bbox_last_of_frame
//                       serialised bbox stream
//   feed_done           one-cycle pulse at the end of a run
//   overflow_err        sticky, a line arrived while the FIFO was full
module oflow_mem_buffer_line_feeder #(
   parameter int BBOX_WIDTH                  = 64,
   parameter int BBOX_PER_LINE               = 2,
   parameter int FIFO_DEPTH                  = 4,
   parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3
) (
   input  logic                                   clk,
   input  logic                                   reset_N,
   input  logic                                   start_feed,
   input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
   output logic                                   similarity_metric_flag_ready_to_read_new_line,
   input  logic                                   line_valid,
   input  logic [BBOX_PER_LINE*BBOX_WIDTH-1:0]    line_data,
   input  logic [BBOX_PER_LINE-1:0]               line_mask,
   input  logic                                   line_last_of_frame,
   output logic                                   bbox_valid,
   input  logic                                   bbox_ready,
   output logic [BBOX_WIDTH-1:0]                  bbox_data,
   output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] bbox_history_idx,
   output logic                                   bbox_last_of_frame,
   output logic                                   feed_done,
   output logic                                   overflow_err
`ifdef OFLOW_LINE_FEEDER_STATS_EN
   ,
   output logic [15:0]                            bbox_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int SW = (BBOX_PER_LINE > 1) ? $clog2(BBOX_PER_LINE) : 1;
   localparam int NW = NUM_OF_HISTORY_FRAMES_WIDTH;
   localparam int LW = BBOX_PER_LINE * BBOX_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DRAIN,
      S_DONE
   } feed_state_t;

   feed_state_t state, state_next;

   logic [LW-1:0]            fifo_data [FIFO_DEPTH];
   logic [BBOX_PER_LINE-1:0] fifo_mask [FIFO_DEPTH];
   logic                     fifo_last [FIFO_DEPTH];
   logic [NW-1:0]            fifo_idx  [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr, count, outstanding;
   logic [NW-1:0] num_frames, frame_idx;
   logic [SW-1:0] slot_ptr, sel_slot;
   logic          sel_found, more_after;
   logic          req, req_q, line_in, push, pop, handshake, last_push;
   logic          full, empty, start_accept;

   logic [LW-1:0]            head_data;
   logic [BBOX_PER_LINE-1:0] head_mask;
   logic                     head_last;

   // Extra pointer bit separates full from empty when the indices match.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == PW'(FIFO_DEPTH));
   assign empty        = (count == '0);
   assign start_accept = (state == S_IDLE) && start_feed;
   assign line_in      = line_valid && (state != S_IDLE);
   assign push         = line_in && !full;

   assign head_data        = fifo_data[rd_ptr[AW-1:0]];
   assign head_mask        = fifo_mask[rd_ptr[AW-1:0]];
   assign head_last        = fifo_last[rd_ptr[AW-1:0]];
   assign bbox_history_idx = fifo_idx[rd_ptr[AW-1:0]];

   // The run's final line: a frame-closing line that completes the last
   // requested frame. Requests stop in the very cycle it is accepted.
   assign last_push = push && line_last_of_frame &&
                      (({1'b0, frame_idx} + (NW+1)'(1)) == {1'b0, num_frames});

   // Find the lowest occupied slot at or above the slot pointer, and note
   // whether any occupied slot lies beyond it (i.e. this is not the last one).
   always_comb begin
      sel_found  = 1'b0;
      more_after = 1'b0;
      sel_slot   = '0;
      for (int k = 0; k < BBOX_PER_LINE; k++) begin
         if (head_mask[k] && (k >= int'(slot_ptr))) begin
            if (!sel_found) begin
               sel_found = 1'b1;
               sel_slot  = SW'(k);
            end else begin
               more_after = 1'b1;
            end
         end
      end
   end

   // Slot multiplexer for the presented bbox.
   always_comb begin
      bbox_data = '0;
      for (int k = 0; k < BBOX_PER_LINE; k++) begin
         if (sel_slot == SW'(k)) bbox_data = head_data[k*BBOX_WIDTH +: BBOX_WIDTH];
      end
   end

   assign bbox_valid         = !empty && sel_found;
   assign handshake          = bbox_valid && bbox_ready;
   assign bbox_last_of_frame = bbox_valid && head_last && !more_after;
   // An all-empty head has nothing to emit and leaves on its own.
   assign pop                = !empty && (!sel_found || (handshake && !more_after));

   // A request is allowed only while lines already held plus lines still
   // owed by the read FSM leave room, and never on two consecutive cycles.
   assign req = (state == S_ACTIVE) && !req_q && !last_push &&
                (({1'b0, count} + {1'b0, outstanding}) < (PW+1)'(FIFO_DEPTH));
   assign similarity_metric_flag_ready_to_read_new_line = req;
   assign feed_done = (state == S_DONE);

   // Run sequencing: DRAIN ends in the cycle the FIFO is about to go empty,
   // so feed_done follows the final bbox handshake by exactly one cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start_accept) state_next = (num_of_history_frames == '0) ? S_DONE : S_ACTIVE;
         end
         S_ACTIVE: begin
            if (last_push) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!push && (empty || ((count == PW'(1)) && pop))) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_N) state <= S_IDLE;
      else          state <= state_next;
   end

   // FIFO pointers, request credits, frame numbering, slot pointer and the
   // sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!reset_N) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= '0;
         req_q        <= 1'b0;
         num_frames   <= '0;
         frame_idx    <= '0;
         slot_ptr     <= '0;
         overflow_err <= 1'b0;
      end else begin
         req_q <= req;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (line_in && full) overflow_err <= 1'b1;

         if (pop)            slot_ptr <= '0;
         else if (handshake) slot_ptr <= sel_slot + SW'(1);

         if (start_accept) begin
            num_frames <= num_of_history_frames;
            frame_idx  <= '0;
         end else if (push && line_last_of_frame) begin
            frame_idx <= frame_idx + NW'(1);
         end

         if (start_accept)                                   outstanding <= '0;
         else if (req && !line_in)                           outstanding <= outstanding + PW'(1);
         else if (!req && line_in && (outstanding != '0))    outstanding <= outstanding - PW'(1);
      end
   end

   // Line storage; contents are qualified by the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr[AW-1:0]] <= line_data;
         fifo_mask[wr_ptr[AW-1:0]] <= line_mask;
         fifo_last[wr_ptr[AW-1:0]] <= line_last_of_frame;
         fifo_idx[wr_ptr[AW-1:0]]  <= frame_idx;
      end
   end

`ifdef OFLOW_LINE_FEEDER_STATS_EN
   // Per-run bbox handshake counter, kept after feed_done until next start.
   always_ff @(posedge clk) begin
      if (!reset_N)          bbox_count <= '0;
      else if (start_accept) bbox_count <= '0;
      else if (handshake)    bbox_count <= bbox_count + 16'd1;
   end
`endif

endmodule
